// File: rtl/tlb_assoc.sv
// Fully-associative TLB with true-LRU replacement, miss/refill handshake and global flush.
// Optional hit/miss performance counters are built in when TLB_PERF_CNT_EN is defined.
module tlb_assoc #(
  parameter int ENTRIES = 4,
  parameter int VA_W    = 32,
  parameter int PA_W    = 20,
  parameter int OFF_W   = 12
) (
  input  logic                  clk_i,
  input  logic                  rsn_i,
  input  logic                  supervisor_i,
  input  logic                  lookup_valid_i,
  input  logic [VA_W-1:0]       v_addr_i,
  input  logic                  write_i,
  output logic                  ready_o,
  output logic                  hit_o,
  output logic [PA_W-1:0]       p_addr_o,
  output logic                  fault_o,
  output logic                  miss_req_o,
  output logic [VA_W-OFF_W-1:0] miss_vpn_o,
  input  logic                  refill_valid_i,
  input  logic [PA_W-OFF_W-1:0] refill_ppn_i,
  input  logic                  refill_ro_i,
  input  logic                  flush_i
`ifdef TLB_PERF_CNT_EN
  ,
  output logic [31:0]           hit_cnt_o,
  output logic [31:0]           miss_cnt_o
`endif
);

  localparam int VPN_W = VA_W - OFF_W;
  localparam int PPN_W = PA_W - OFF_W;
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {S_IDLE, S_MISS} state_t;

  state_t             state_q, state_d;
  logic [VPN_W-1:0]   miss_vpn_q, miss_vpn_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [VPN_W-1:0]   vpn_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q [ENTRIES];
  logic               ro_q  [ENTRIES];
  logic [IDX_W-1:0]   age_q [ENTRIES];
  logic [IDX_W-1:0]   age_d [ENTRIES];

  logic [VPN_W-1:0]   va_vpn;
  logic               lookup_act;
  logic               lk_hit, rf_hit, inv_found;
  logic [IDX_W-1:0]   lk_idx, rf_idx, inv_idx, lru_idx, victim;
  logic               touch_en, wr_en;
  logic [IDX_W-1:0]   touch_idx, touch_age;

  assign va_vpn     = v_addr_i[VA_W-1:OFF_W];
  assign lookup_act = (state_q == S_IDLE) && lookup_valid_i && !supervisor_i;
  assign ready_o    = (state_q == S_IDLE);
  assign miss_req_o = (state_q == S_MISS);
  assign miss_vpn_o = miss_vpn_q;

  // Lookup match and refill victim selection
  always_comb begin
    lk_hit    = 1'b0;
    lk_idx    = '0;
    rf_hit    = 1'b0;
    rf_idx    = '0;
    inv_found = 1'b0;
    inv_idx   = '0;
    lru_idx   = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && vpn_q[i] == va_vpn) begin
        lk_hit = 1'b1;
        lk_idx = IDX_W'(i);
      end
      if (valid_q[i] && vpn_q[i] == miss_vpn_q) begin
        rf_hit = 1'b1;
        rf_idx = IDX_W'(i);
      end
      if (age_q[i] == IDX_W'(ENTRIES - 1)) lru_idx = IDX_W'(i);
    end
    // Scan downward so the lowest invalid index wins
    for (int unsigned i = ENTRIES; i > 0; i--) begin
      if (!valid_q[i-1]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i - 1);
      end
    end
    victim = rf_hit ? rf_idx : (inv_found ? inv_idx : lru_idx);
  end

  always_comb begin
    hit_o    = 1'b0;
    p_addr_o = '0;
    fault_o  = 1'b0;
    if (supervisor_i) begin
      hit_o    = 1'b1;
      p_addr_o = v_addr_i[PA_W-1:0];
    end else if (lookup_act && lk_hit) begin
      hit_o    = 1'b1;
      p_addr_o = {ppn_q[lk_idx], v_addr_i[OFF_W-1:0]};
      fault_o  = write_i && ro_q[lk_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    miss_vpn_d = miss_vpn_q;
    valid_d    = valid_q;
    touch_en   = 1'b0;
    touch_idx  = lk_idx;
    wr_en      = 1'b0;
    if (flush_i) begin
      valid_d = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (lookup_act) begin
            if (lk_hit) begin
              touch_en = 1'b1;
            end else begin
              state_d    = S_MISS;
              miss_vpn_d = va_vpn;
            end
          end
        end
        S_MISS: begin
          if (refill_valid_i) begin
            wr_en           = 1'b1;
            valid_d[victim] = 1'b1;
            touch_en        = 1'b1;
            touch_idx       = victim;
            state_d         = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Touch: entry goes to age 0, everything younger than it ages by one
  always_comb begin
    touch_age = age_q[touch_idx];
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      age_d[i] = age_q[i];
      if (touch_en) begin
        if (IDX_W'(i) == touch_idx)      age_d[i] = '0;
        else if (age_q[i] < touch_age)   age_d[i] = age_q[i] + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_q    <= S_IDLE;
      miss_vpn_q <= '0;
      valid_q    <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
    end else begin
      state_q    <= state_d;
      miss_vpn_q <= miss_vpn_d;
      valid_q    <= valid_d;
      age_q      <= age_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en && !rsn_i) begin
      vpn_q[victim] <= miss_vpn_q;
      ppn_q[victim] <= refill_ppn_i;
      ro_q[victim]  <= refill_ro_i;
    end
  end

`ifdef TLB_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (lookup_act) begin
      if (lk_hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
      else        miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tlb_assoc.sv
// Scoreboard bench for tlb_assoc: a recency-list reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_tlb_assoc;
  localparam int ENTRIES = 4;
  localparam int VA_W = 32, PA_W = 20, OFF_W = 12;
  localparam int VPN_W = VA_W - OFF_W, PPN_W = PA_W - OFF_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rsn_i, supervisor_i, lookup_valid_i, write_i;
  logic [VA_W-1:0]  v_addr_i;
  logic             ready_o, hit_o, fault_o, miss_req_o;
  logic [PA_W-1:0]  p_addr_o;
  logic [VPN_W-1:0] miss_vpn_o;
  logic             refill_valid_i, refill_ro_i, flush_i;
  logic [PPN_W-1:0] refill_ppn_i;
`ifdef TLB_PERF_CNT_EN
  logic [31:0]      hit_cnt_o, miss_cnt_o;
`endif

  tlb_assoc #(.ENTRIES(ENTRIES), .VA_W(VA_W), .PA_W(PA_W), .OFF_W(OFF_W)) u_dut (
    .clk_i(clk), .rsn_i(rsn_i), .supervisor_i(supervisor_i),
    .lookup_valid_i(lookup_valid_i), .v_addr_i(v_addr_i), .write_i(write_i),
    .ready_o(ready_o), .hit_o(hit_o), .p_addr_o(p_addr_o), .fault_o(fault_o),
    .miss_req_o(miss_req_o), .miss_vpn_o(miss_vpn_o),
    .refill_valid_i(refill_valid_i), .refill_ppn_i(refill_ppn_i),
    .refill_ro_i(refill_ro_i), .flush_i(flush_i)
`ifdef TLB_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  typedef struct {
    logic             hit;
    logic [PA_W-1:0]  pa;
    logic             fault;
    logic             ready;
    logic             mreq;
    logic [VPN_W-1:0] mvpn;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  // Reference model: entry table plus recency list (front = most recently used)
  bit               m_valid [ENTRIES];
  logic [VPN_W-1:0] m_vpn   [ENTRIES];
  logic [PPN_W-1:0] m_ppn   [ENTRIES];
  bit               m_ro    [ENTRIES];
  int               rec[$];
  bit               m_miss;
  logic [VPN_W-1:0] m_mvpn;
  logic [31:0]      m_hits, m_misses;

  function automatic int find(input logic [VPN_W-1:0] v);
    for (int i = 0; i < ENTRIES; i++)
      if (m_valid[i] && m_vpn[i] == v) return i;
    return -1;
  endfunction

  function automatic void touch(input int k);
    for (int j = 0; j < rec.size(); j++)
      if (rec[j] == k) begin
        rec.delete(j);
        break;
      end
    rec.push_front(k);
  endfunction

  function automatic void model_reset();
    rec.delete();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      rec.push_back(i);
    end
    m_miss = 1'b0;
    m_mvpn = '0;
    m_hits = '0;
    m_misses = '0;
  endfunction

  task automatic step(input bit rst, input bit sup, input bit lv, input logic [31:0] va,
                      input bit wr, input bit rv, input logic [PPN_W-1:0] ppn,
                      input bit ro, input bit fl);
    exp_t e;
    int k, v;
    logic [VPN_W-1:0] vpn;
    vpn = va[VA_W-1:OFF_W];
    rsn_i = rst; supervisor_i = sup; lookup_valid_i = lv; v_addr_i = va; write_i = wr;
    refill_valid_i = rv; refill_ppn_i = ppn; refill_ro_i = ro; flush_i = fl;
    k = find(vpn);
    e.ready = !m_miss;
    e.mreq  = m_miss;
    e.mvpn  = m_mvpn;
    e.hit = 1'b0; e.pa = '0; e.fault = 1'b0;
    if (sup) begin
      e.hit = 1'b1;
      e.pa  = va[PA_W-1:0];
    end else if (!m_miss && lv && k >= 0) begin
      e.hit   = 1'b1;
      e.pa    = {m_ppn[k], va[OFF_W-1:0]};
      e.fault = wr && m_ro[k];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      if (!m_miss && lv && !sup) begin
        if (k >= 0) m_hits++;
        else        m_misses++;
      end
      if (fl) begin
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_miss = 1'b0;
      end else if (!m_miss && lv && !sup) begin
        if (k >= 0) touch(k);
        else begin
          m_miss = 1'b1;
          m_mvpn = vpn;
        end
      end else if (m_miss && rv) begin
        v = find(m_mvpn);
        if (v < 0)
          for (int i = ENTRIES - 1; i >= 0; i--)
            if (!m_valid[i]) v = i;
        if (v < 0) v = rec[rec.size() - 1];
        m_valid[v] = 1'b1;
        m_vpn[v] = m_mvpn;
        m_ppn[v] = ppn;
        m_ro[v]  = ro;
        touch(v);
        m_miss = 1'b0;
      end
    end
`ifdef TLB_PERF_CNT_EN
    chk("hit_cnt", hit_cnt_o, m_hits);
    chk("miss_cnt", miss_cnt_o, m_misses);
`endif
  endtask

  task automatic lookup(input logic [31:0] va, input bit wr);
    step(0, 0, 1, va, wr, 0, '0, 0, 0);
  endtask

  // Miss, refill while the lookup is held, then retry
  task automatic fill(input logic [VPN_W-1:0] vpn, input logic [PPN_W-1:0] ppn, input bit ro);
    logic [31:0] va;
    va = {vpn, 12'h5A5};
    lookup(va, 0);
    step(0, 0, 1, va, 0, 1, ppn, ro, 0);
    lookup(va, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hit_o",      32'(hit_o),      32'(e.hit));
      chk("p_addr_o",   32'(p_addr_o),   32'(e.pa));
      chk("fault_o",    32'(fault_o),    32'(e.fault));
      chk("ready_o",    32'(ready_o),    32'(e.ready));
      chk("miss_req_o", 32'(miss_req_o), 32'(e.mreq));
      chk("miss_vpn_o", 32'(miss_vpn_o), 32'(e.mvpn));
    end
  end

  initial begin
    rsn_i = 1'b1; supervisor_i = 0; lookup_valid_i = 0; v_addr_i = '0; write_i = 0;
    refill_valid_i = 0; refill_ppn_i = '0; refill_ro_i = 0; flush_i = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset-state sample, first miss and refill
    step(0, 0, 0, '0, 0, 0, '0, 0, 0);
    lookup(32'h0000_3ABC, 0);
    step(0, 0, 1, 32'h0000_3ABC, 0, 1, 8'h45, 0, 0);
    lookup(32'h0000_3ABC, 0);

    // LRU replacement
    step(1, 0, 0, '0, 0, 0, '0, 0, 0);
    for (int i = 1; i <= 4; i++) fill(VPN_W'(i), PPN_W'(8'h10 + i), 0);
    lookup(32'h0000_1123, 0);
    fill(20'd5, 8'h55, 0);
    lookup(32'h0000_1FFF, 0);
    fill(20'd2, 8'h22, 0);

    // Write-protection fault and stale refill in IDLE
    fill(20'd6, 8'h66, 1);
    lookup(32'h0000_6321, 1);
    lookup(32'h0000_6321, 0);
    step(0, 0, 0, '0, 0, 1, 8'h77, 0, 0);

    // Flush against a same-cycle refill, then supervisor bypass
    lookup(32'h0000_9000, 0);
    step(0, 0, 1, 32'h0000_9000, 0, 1, 8'h99, 0, 1);
    lookup(32'h0000_9000, 0);
    step(0, 0, 1, 32'h0000_9000, 0, 0, '0, 0, 1);
    step(0, 1, 1, 32'h1234_5678, 1, 0, '0, 0, 0);
    step(0, 1, 0, 32'h1234_5678, 0, 0, '0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] va;
      va = {17'h0, 3'($urandom_range(0, 7)), 12'($urandom)};
      step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
           va, 1'($urandom), $urandom_range(0, 2) == 0, 8'($urandom), 1'($urandom),
           $urandom_range(0, 31) == 0);
    end

    lookup_valid_i = 0; supervisor_i = 0; refill_valid_i = 0; flush_i = 0;
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
